seg7_scan_driver: RTL
=====================

// Module: seg7_scan_driver
// PURPOSE
//  Time-multiplexed driver for the Basys3 4-digit common-anode 7-segment display.
//  Takes four BCD digits plus decimal points from an upstream counter or value source.
//  Drives the active-low SEG, DP and AN pins, scanning one digit at a time.
//  New values are double-buffered: a load is applied only at a frame boundary, so a
//  displayed frame never mixes old and new digits. Optional leading-zero blanking and
//  an anti-ghost gap between digits.
// PARAMETERS
//  CLK_HZ        100_000_000  input clock frequency, Hz
//  REFRESH_HZ    1_000        per-digit dwell rate; DWELL = CLK_HZ/REFRESH_HZ cycles
//  GAP_CYCLES    1_000        blank cycles (AN=4'b1111) at end of each dwell; 0 <= GAP_CYCLES < DWELL
//  BLANK_LEADING 1            1 = blank leading zeros on digits 3..1; 0 = show all digits
// PORTS
//  CLK     in   1   system clock, rising edge
//  RST_N   in   1   asynchronous, active-low reset
//  ENABLE  in   1   1 = scan display; 0 = all digits off
//  LOAD    in   1   single-cycle strobe; captures DIGITS/DP_IN
//  DIGITS  in   16  BCD digits; [3:0] = digit0 (rightmost, AN0) ... [15:12] = digit3
//  DP_IN   in   4   decimal point per digit, 1 = lit; bit i maps to digit i
//  SEG     out  7   segments {g,f,e,d,c,b,a}, active-low, registered
//  DP      out  1   decimal point, active-low, registered
//  AN      out  4   digit anodes, active-low, registered; AN[i] selects digit i
//  FRAME   out  1   1-cycle pulse when scan index wraps 3 -> 0
// BEHAVIOUR
//  Reset (async, RST_N=0):
//   - SEG=7'b1111111, DP=1, AN=4'b1111, FRAME=0.
//   - idx=0, cnt=0; active and pending regs = 0; pend flag = 0.
//  Timebase:
//   - cnt counts 0..DWELL-1 while ENABLE=1.
//   - At cnt==DWELL-1: cnt<=0, idx<=idx+1 (mod 4).
//   - FRAME=1 for one cycle when idx changes 3 -> 0.
//  Phases (decoded from cnt):
//   - SHOW when cnt < DWELL-GAP_CYCLES.
//   - GAP otherwise; GAP drives AN=4'b1111, SEG=7'b1111111, DP=1.
//  Output latency: SEG/DP/AN are registered and lag the cnt/idx decode by exactly 1 cycle.
//  SHOW outputs: AN = ~(4'b0001<<idx); SEG = decode(active digit idx); DP = ~active_dp[idx].
//  Decode table (gfedcba, active-low):
//   0=1000000 1=1111001 2=0100100 3=0110000 4=0011001
//   5=0010010 6=0000010 7=1111000 8=0000000 9=0010000
//   nibble A..F -> 1111111 (blank)
//  Leading-zero blanking (BLANK_LEADING=1):
//   - Digit i (i=3..1) shows SEG=1111111 if it and all higher digits are 0.
//   - Digit 0 is never blanked.
//   - DP is still driven from active_dp on a blanked digit.
//  Load / double buffer:
//   - LOAD=1 -> pending <= {DIGITS,DP_IN}, pend<=1. A later LOAD before the boundary overwrites pending.
//   - At a frame boundary (cycle idx wraps 3->0): active <= LOAD ? {DIGITS,DP_IN} : pending,
//     applied only if pend or LOAD is set; pend<=0. Simultaneous LOAD wins.
//  ENABLE=0 (IDLE):
//   - cnt,idx held at 0; AN=4'b1111, SEG=7'b1111111, DP=1 from next cycle.
//   - FRAME=0.
//   - LOAD copies straight to active next cycle, pend cleared.
//  ENABLE 0->1: scan restarts at idx=0, cnt=0; first AN=4'b1110 one cycle later.
//  ENABLE 1->0 mid-dwell: blank next cycle; any pending value is committed to active.
//  Reset mid-frame: all state returns to reset values immediately; no partial load survives.
// TESTING  (bench uses CLK_HZ=1000, REFRESH_HZ=100 -> DWELL=10, GAP_CYCLES=2)
//  1. Reset release, ENABLE=1, no LOAD -> AN sequence 1110,1101,1011,0111.
//     Each digit is on 8 cycles, then 1111 for 2. SEG=1000000 on AN0 only; digits 3..1 blank.
//     FRAME pulses every 40 cycles.
//  2. LOAD DIGITS=16'h1234, DP_IN=4'b0100 mid-frame -> old value holds until the wrap.
//     Next frame shows 4,3,2,1 on AN0..AN3; DP=0 only while AN=1011.
//  3. LOAD 16'h0070 then 16'h0805 in the same frame -> next frame shows only 0805.
//     Digit3 is blank; digit2 shows 0000000.
//  4. LOAD 16'h0009 on the exact wrap cycle -> that frame already shows 9 on AN0; pend=0 afterwards.
//  5. ENABLE=0 mid-dwell -> AN=1111, SEG=1111111 the next cycle.
//     LOAD 16'h00AF then ENABLE=1 -> AN0 and AN1 show SEG=1111111 (non-BCD).
//  6. Assert RST_N=0 during GAP of idx=2 -> outputs are at reset values within the same cycle.
//     After release, scan restarts at AN=1110.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// ---------------------------------------------------------------------------
// seg7_scan_driver
//
// Purpose:
//    Time-multiplexed driver for the Basys3 4-digit common-anode 7-segment
//    display. Four BCD digits and their decimal points are scanned one digit
//    at a time. New values are double-buffered and only take effect at a
//    frame boundary, so one frame never mixes old and new digits. Leading-zero
//    blanking and an anti-ghost gap at the end of each dwell are optional.
//
// Parameters:
//    CLK_HZ        input clock frequency in Hz
//    REFRESH_HZ    per-digit dwell rate; DWELL = CLK_HZ/REFRESH_HZ cycles
//    GAP_CYCLES    blank cycles at the end of each dwell (0 <= GAP < DWELL)
//    BLANK_LEADING 1 = blank leading zeros on digits 3..1
//
// Ports:
//    clk_i      system clock, rising edge
//    rst_ni     asynchronous active-low reset
//    enable_i   1 = scan display, 0 = all digits off
//    load_i     single-cycle strobe capturing digits_i / dp_i
//    digits_i   BCD digits, [3:0] = digit0 (AN0) ... [15:12] = digit3
//    dp_i       decimal point per digit, 1 = lit
//    seg_o      segments {g,f,e,d,c,b,a}, active-low, registered
//    dp_o       decimal point, active-low, registered
//    an_o       digit anodes, active-low, registered
//    frame_o    1-cycle pulse when the scan index wraps 3 -> 0
// ---------------------------------------------------------------------------
module seg7_scan_driver #(
   parameter int CLK_HZ        = 100_000_000,
   parameter int REFRESH_HZ    = 1_000,
   parameter int GAP_CYCLES    = 1_000,
   parameter bit BLANK_LEADING = 1'b1
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        enable_i,
   input  logic        load_i,
   input  logic [15:0] digits_i,
   input  logic [3:0]  dp_i,
   output logic [6:0]  seg_o,
   output logic        dp_o,
   output logic [3:0]  an_o,
   output logic        frame_o
);

   localparam int DWELL = CLK_HZ / REFRESH_HZ;
   // One spare bit of headroom so SHOW_LEN == DWELL (GAP_CYCLES = 0) still fits.
   localparam int CW = $clog2(DWELL + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);
   localparam logic [CW-1:0] SHOW_LEN = CW'(DWELL - GAP_CYCLES);

   localparam logic [6:0] SEG_OFF = 7'b1111111;

   // Active-low segment pattern for one BCD nibble; non-BCD codes are blank.
   function automatic logic [6:0] bcdToSeg(input logic [3:0] nib);
      logic [6:0] s;
      case (nib)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = SEG_OFF;
      endcase
      return s;
   endfunction

   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    idx_q, idx_d;
   logic [15:0]   activeDig_q, activeDig_d;
   logic [3:0]    activeDp_q, activeDp_d;
   logic [15:0]   pendDig_q, pendDig_d;
   logic [3:0]    pendDp_q, pendDp_d;
   logic          pend_q, pend_d;
   logic [6:0]    seg_q, seg_d;
   logic          dp_q, dp_d;
   logic [3:0]    an_q, an_d;
   logic          frame_q, frame_d;

   logic          lastCycle;
   logic          wrap;
   logic [3:0]    curDigit;
   logic [3:0]    zeroAbove;
   logic          blankDigit;

   // Digit i is a leading zero when it and every digit above it are zero.
   // Digit 0 always shows, so its mask bit is tied low.
   always_comb begin
      zeroAbove[3] = (activeDig_q[15:12] == 4'd0);
      zeroAbove[2] = zeroAbove[3] && (activeDig_q[11:8] == 4'd0);
      zeroAbove[1] = zeroAbove[2] && (activeDig_q[7:4] == 4'd0);
      zeroAbove[0] = 1'b0;
      curDigit     = activeDig_q[{idx_q, 2'b00} +: 4];
      blankDigit   = BLANK_LEADING && zeroAbove[idx_q];
      lastCycle    = (cnt_q == CNT_LAST);
      wrap         = lastCycle && (idx_q == 2'd3);
   end

   // Next-state logic: timebase, double buffer and the registered pin values.
   // Pins are computed from the current cnt/idx and registered, so they lag
   // the decode by one cycle. The active buffer only changes on the wrap cycle
   // while scanning, or immediately while idle.
   always_comb begin
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      activeDig_d = activeDig_q;
      activeDp_d  = activeDp_q;
      pendDig_d   = pendDig_q;
      pendDp_d    = pendDp_q;
      pend_d      = pend_q;
      seg_d       = SEG_OFF;
      dp_d        = 1'b1;
      an_d        = 4'b1111;
      frame_d     = 1'b0;

      if (load_i) begin
         pendDig_d = digits_i;
         pendDp_d  = dp_i;
      end

      if (!enable_i) begin
         cnt_d  = '0;
         idx_d  = 2'd0;
         pend_d = 1'b0;
         if (load_i) begin
            activeDig_d = digits_i;
            activeDp_d  = dp_i;
         end else if (pend_q) begin
            activeDig_d = pendDig_q;
            activeDp_d  = pendDp_q;
         end
      end else begin
         if (lastCycle) begin
            cnt_d = '0;
            idx_d = idx_q + 2'd1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
         frame_d = wrap;

         // A LOAD landing on the wrap cycle bypasses the pending buffer.
         if (wrap) begin
            pend_d = 1'b0;
            if (load_i) begin
               activeDig_d = digits_i;
               activeDp_d  = dp_i;
            end else if (pend_q) begin
               activeDig_d = pendDig_q;
               activeDp_d  = pendDp_q;
            end
         end else if (load_i) begin
            pend_d = 1'b1;
         end

         if (cnt_q < SHOW_LEN) begin
            an_d  = ~(4'b0001 << idx_q);
            seg_d = blankDigit ? SEG_OFF : bcdToSeg(curDigit);
            dp_d  = ~activeDp_q[idx_q];
         end
      end
   end

   // State and output registers; reset puts the display dark and the scan at digit 0.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q       <= '0;
         idx_q       <= 2'd0;
         activeDig_q <= 16'd0;
         activeDp_q  <= 4'd0;
         pendDig_q   <= 16'd0;
         pendDp_q    <= 4'd0;
         pend_q      <= 1'b0;
         seg_q       <= SEG_OFF;
         dp_q        <= 1'b1;
         an_q        <= 4'b1111;
         frame_q     <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         activeDig_q <= activeDig_d;
         activeDp_q  <= activeDp_d;
         pendDig_q   <= pendDig_d;
         pendDp_q    <= pendDp_d;
         pend_q      <= pend_d;
         seg_q       <= seg_d;
         dp_q        <= dp_d;
         an_q        <= an_d;
         frame_q     <= frame_d;
      end
   end

   assign seg_o   = seg_q;
   assign dp_o    = dp_q;
   assign an_o    = an_q;
   assign frame_o = frame_q;

endmodule
